// File: rtl/infra_reset_sequencer.sv
// -----------------------------------------------------------------------------
// infra_reset_sequencer
//
// Power-up / recovery sequencer for the board clock infrastructure.
// The MMCM lock is first qualified by a consecutive-cycle filter. Once the
// lock has been held for a settling period, the IDELAYCTRL reset is pulsed.
// The block then waits for IDELAYCTRL ready. That wait has a timeout and a
// bounded number of retries. After ready arrives, the downstream domain
// resets are released one at a time in a fixed order. Loss of lock, loss of
// ready or a software request puts the resets back on, and the sequence
// starts again.
//
// Ports
//   sys_clk0      in   1          sequencer clock
//   sync_rst      in   1          asynchronous, active-high reset
//   mmcm_locked   in   1          MMCM LOCKED (already synchronous to sys_clk0)
//   idelay_rdy    in   1          IDELAYCTRL RDY (already synchronous to sys_clk0)
//   soft_rst_req  in   1          one-cycle pulse: restart, clear fault/retries
//   idelay_rst    out  1          IDELAYCTRL reset, active-high
//   rst_out       out  N_DOMAINS  domain resets, active-high, bit 0 released first
//   seq_done      out  1          high only in RUN
//   fault         out  1          high only in FAULT
//   retry_cnt     out  3          IDELAYCTRL retries consumed
//   state_o       out  3          HOLD=0 IDLY_RST=1 WAIT_RDY=2 RELEASE=3 RUN=4 FAULT=5
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module infra_reset_sequencer #(
   parameter int N_DOMAINS         = 4,
   parameter int LOCK_FILTER       = 8,
   parameter int HOLD_CYCLES       = 16,
   parameter int IDELAY_RST_CYCLES = 64,
   parameter int RDY_TIMEOUT       = 4096,
   parameter int STAGE_GAP         = 8,
   parameter int MAX_RETRIES       = 3
) (
   input  logic                 sys_clk0,
   input  logic                 sync_rst,
   input  logic                 mmcm_locked,
   input  logic                 idelay_rdy,
   input  logic                 soft_rst_req,
   output logic                 idelay_rst,
   output logic [N_DOMAINS-1:0] rst_out,
   output logic                 seq_done,
   output logic                 fault,
   output logic [2:0]           retry_cnt,
   output logic [2:0]           state_o
);

   typedef enum logic [2:0] {
      ST_HOLD     = 3'd0,
      ST_IDLY_RST = 3'd1,
      ST_WAIT_RDY = 3'd2,
      ST_RELEASE  = 3'd3,
      ST_RUN      = 3'd4,
      ST_FAULT    = 3'd5
   } state_t;

   // One shared phase counter covers every timed interval. It only ever needs
   // to reach (longest interval - 1), so it is sized for that and never wraps.
   localparam int CNT_M1  = (RDY_TIMEOUT > IDELAY_RST_CYCLES) ? RDY_TIMEOUT : IDELAY_RST_CYCLES;
   localparam int CNT_M2  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CNT_MAX = (CNT_M1 > CNT_M2) ? CNT_M1 : CNT_M2;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] IRST_LAST = CNT_W'(IDELAY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(RDY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

   localparam int LF_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
   localparam logic [LF_W-1:0] LF_ONE  = LF_W'(1);
   localparam logic [LF_W-1:0] LF_LAST = LF_W'(LOCK_FILTER - 1);

   localparam int K_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
   localparam logic [K_W-1:0] K_ONE  = K_W'(1);
   localparam logic [K_W-1:0] K_LAST = K_W'(N_DOMAINS - 1);

   localparam logic [2:0]           RETRY_MAX = 3'(MAX_RETRIES);
   localparam logic [N_DOMAINS-1:0] ALL_RST   = {N_DOMAINS{1'b1}};

   state_t                 state_q,      state_d;
   logic [CNT_W-1:0]       cnt_q,        cnt_d;
   logic [K_W-1:0]         stage_q,      stage_d;
   logic [LF_W-1:0]        lf_cnt_q,     lf_cnt_d;
   logic                   lock_ok_q,    lock_ok_d;
   logic [2:0]             retry_q,      retry_d;
   logic [N_DOMAINS-1:0]   rst_out_q,    rst_out_d;
   logic                   idelay_rst_q, idelay_rst_d;
   logic                   seq_done_q,   seq_done_d;
   logic                   fault_q,      fault_d;

   // lock_ok is about to fall. React in the same cycle that lock_ok clears.
   // The resets then come back on one cycle after the low sample.
   logic lock_lost_s;
   assign lock_lost_s = lock_ok_q & ~mmcm_locked;

   // Lock qualification filter: count consecutive locked samples, drop on any low sample.
   always_comb begin
      lf_cnt_d  = lf_cnt_q;
      lock_ok_d = lock_ok_q;
      if (!mmcm_locked) begin
         lf_cnt_d  = {LF_W{1'b0}};
         lock_ok_d = 1'b0;
      end else if (lock_ok_q) begin
         lf_cnt_d  = lf_cnt_q;
         lock_ok_d = 1'b1;
      end else if (lf_cnt_q == LF_LAST) begin
         // This is the LOCK_FILTER-th consecutive high sample.
         lf_cnt_d  = lf_cnt_q;
         lock_ok_d = 1'b1;
      end else begin
         lf_cnt_d  = lf_cnt_q + LF_ONE;
         lock_ok_d = 1'b0;
      end
   end

   // Sequencer next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stage_d      = stage_q;
      retry_d      = retry_q;
      rst_out_d    = rst_out_q;
      idelay_rst_d = idelay_rst_q;
      seq_done_d   = seq_done_q;
      fault_d      = fault_q;

      if (lock_lost_s && (state_q != ST_FAULT)) begin
         // Lock loss outranks the software request. It keeps retry history.
         state_d      = ST_HOLD;
         cnt_d        = {CNT_W{1'b0}};
         stage_d      = {K_W{1'b0}};
         rst_out_d    = ALL_RST;
         idelay_rst_d = 1'b1;
         seq_done_d   = 1'b0;
         fault_d      = 1'b0;
      end else if (soft_rst_req) begin
         state_d      = ST_HOLD;
         cnt_d        = {CNT_W{1'b0}};
         stage_d      = {K_W{1'b0}};
         retry_d      = 3'd0;
         rst_out_d    = ALL_RST;
         idelay_rst_d = 1'b1;
         seq_done_d   = 1'b0;
         fault_d      = 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               rst_out_d    = ALL_RST;
               idelay_rst_d = 1'b1;
               if (!lock_ok_q) begin
                  cnt_d = {CNT_W{1'b0}};
               end else if (cnt_q == HOLD_LAST) begin
                  state_d = ST_IDLY_RST;
                  cnt_d   = {CNT_W{1'b0}};
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            ST_IDLY_RST: begin
               if (cnt_q == IRST_LAST) begin
                  state_d      = ST_WAIT_RDY;
                  cnt_d        = {CNT_W{1'b0}};
                  idelay_rst_d = 1'b0;
               end else begin
                  cnt_d        = cnt_q + CNT_ONE;
                  idelay_rst_d = 1'b1;
               end
            end

            ST_WAIT_RDY: begin
               // Ready is tested first, so it wins over a timeout in the same cycle.
               if (idelay_rdy) begin
                  state_d = ST_RELEASE;
                  cnt_d   = {CNT_W{1'b0}};
                  stage_d = {K_W{1'b0}};
               end else if (cnt_q == TO_LAST) begin
                  cnt_d        = {CNT_W{1'b0}};
                  idelay_rst_d = 1'b1;
                  if (retry_q < RETRY_MAX) begin
                     state_d = ST_IDLY_RST;
                     retry_d = retry_q + 3'd1;
                  end else begin
                     state_d = ST_FAULT;
                     fault_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            ST_RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  rst_out_d[stage_q] = 1'b0;
                  cnt_d              = {CNT_W{1'b0}};
                  if (stage_q == K_LAST) begin
                     state_d    = ST_RUN;
                     stage_d    = {K_W{1'b0}};
                     seq_done_d = 1'b1;
                  end else begin
                     stage_d = stage_q + K_ONE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            ST_RUN: begin
               // Ready loss re-pulses IDELAYCTRL. It does not count as a retry.
               if (!idelay_rdy) begin
                  state_d      = ST_IDLY_RST;
                  cnt_d        = {CNT_W{1'b0}};
                  rst_out_d    = ALL_RST;
                  idelay_rst_d = 1'b1;
                  seq_done_d   = 1'b0;
               end else begin
                  state_d = ST_RUN;
               end
            end

            ST_FAULT: begin
               rst_out_d    = ALL_RST;
               idelay_rst_d = 1'b1;
               fault_d      = 1'b1;
            end

            default: begin
               // Unreachable encoding: fall back to the fully reset HOLD state.
               state_d      = ST_HOLD;
               cnt_d        = {CNT_W{1'b0}};
               stage_d      = {K_W{1'b0}};
               rst_out_d    = ALL_RST;
               idelay_rst_d = 1'b1;
               seq_done_d   = 1'b0;
               fault_d      = 1'b0;
            end
         endcase
      end
   end

   // State and output registers. Reset forces every domain back into reset at once.
   always_ff @(posedge sys_clk0 or posedge sync_rst) begin
      if (sync_rst) begin
         state_q      <= ST_HOLD;
         cnt_q        <= {CNT_W{1'b0}};
         stage_q      <= {K_W{1'b0}};
         lf_cnt_q     <= {LF_W{1'b0}};
         lock_ok_q    <= 1'b0;
         retry_q      <= 3'd0;
         rst_out_q    <= ALL_RST;
         idelay_rst_q <= 1'b1;
         seq_done_q   <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stage_q      <= stage_d;
         lf_cnt_q     <= lf_cnt_d;
         lock_ok_q    <= lock_ok_d;
         retry_q      <= retry_d;
         rst_out_q    <= rst_out_d;
         idelay_rst_q <= idelay_rst_d;
         seq_done_q   <= seq_done_d;
         fault_q      <= fault_d;
      end
   end

   assign idelay_rst = idelay_rst_q;
   assign rst_out    = rst_out_q;
   assign seq_done   = seq_done_q;
   assign fault      = fault_q;
   assign retry_cnt  = retry_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_infra_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_infra_reset_sequencer
//
// Testbench for infra_reset_sequencer with the default parameters.
// - A fixed table of stimulus/expected-output records walks through the
//   clean bring-up, a RUN disturbance, a lock glitch and a software restart.
// - Hand-written sequences cover timeout/retry into FAULT, simultaneous
//   events, and the asynchronous reset.
// - A final random phase drives mmcm_locked, idelay_rdy and soft_rst_req.
// A reference model runs alongside the whole test. It works in terms of
// "phase + cycles elapsed in the phase" and "consecutive locked samples".
// Every cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_infra_reset_sequencer;

   localparam int N   = 4;
   localparam int LF  = 8;
   localparam int HC  = 16;
   localparam int IRC = 64;
   localparam int TO  = 4096;
   localparam int GAP = 8;
   localparam int MR  = 3;

   logic         sys_clk0 = 1'b0;
   logic         sync_rst;
   logic         mmcm_locked;
   logic         idelay_rdy;
   logic         soft_rst_req;
   logic         idelay_rst;
   logic [N-1:0] rst_out;
   logic         seq_done;
   logic         fault;
   logic [2:0]   retry_cnt;
   logic [2:0]   state_o;

   int n_cmp = 0;
   int n_err = 0;

   infra_reset_sequencer #(
      .N_DOMAINS(N), .LOCK_FILTER(LF), .HOLD_CYCLES(HC), .IDELAY_RST_CYCLES(IRC),
      .RDY_TIMEOUT(TO), .STAGE_GAP(GAP), .MAX_RETRIES(MR)
   ) dut (
      .sys_clk0(sys_clk0), .sync_rst(sync_rst), .mmcm_locked(mmcm_locked),
      .idelay_rdy(idelay_rdy), .soft_rst_req(soft_rst_req), .idelay_rst(idelay_rst),
      .rst_out(rst_out), .seq_done(seq_done), .fault(fault), .retry_cnt(retry_cnt),
      .state_o(state_o)
   );

   always #5 sys_clk0 = ~sys_clk0;

   // ---------------- reference model ----------------
   // phases: 0 HOLD, 1 IDLY_RST, 2 WAIT_RDY, 3 RELEASE, 4 RUN, 5 FAULT
   int m_run;      // consecutive locked samples seen
   int m_phase;
   int m_el;       // cycles elapsed in the current phase
   int m_retries;

   task model_reset();
      m_run = 0; m_phase = 0; m_el = 0; m_retries = 0;
   endtask

   task model_step(input logic l, input logic r, input logic s);
      bit prev_ok;
      prev_ok = (m_run >= LF);
      if (l) begin
         if (m_run < 100000) m_run = m_run + 1;
      end else begin
         m_run = 0;
      end
      if (prev_ok && !l && m_phase != 5) begin
         m_phase = 0; m_el = 0;
      end else if (s) begin
         m_phase = 0; m_el = 0; m_retries = 0;
      end else begin
         case (m_phase)
            0: begin
               if (prev_ok) begin
                  m_el = m_el + 1;
                  if (m_el == HC) begin m_phase = 1; m_el = 0; end
               end else begin
                  m_el = 0;
               end
            end
            1: begin
               m_el = m_el + 1;
               if (m_el == IRC) begin m_phase = 2; m_el = 0; end
            end
            2: begin
               if (r) begin
                  m_phase = 3; m_el = 0;
               end else begin
                  m_el = m_el + 1;
                  if (m_el == TO) begin
                     m_el = 0;
                     if (m_retries < MR) begin m_retries = m_retries + 1; m_phase = 1; end
                     else m_phase = 5;
                  end
               end
            end
            3: begin
               m_el = m_el + 1;
               if (m_el == N * GAP) begin m_phase = 4; m_el = 0; end
            end
            4: begin
               if (!r) begin m_phase = 1; m_el = 0; end
            end
            default: begin end
         endcase
      end
   endtask

   task model_outputs(output logic [2:0] st, output logic [N-1:0] ro, output logic ir,
                      output logic sd, output logic ft, output logic [2:0] rc);
      logic [N-1:0] ones;
      ones = {N{1'b1}};
      st = 3'(m_phase);
      if (m_phase == 3)      ro = ones << (m_el / GAP);
      else if (m_phase == 4) ro = {N{1'b0}};
      else                   ro = ones;
      ir = (m_phase == 0 || m_phase == 1 || m_phase == 5);
      sd = (m_phase == 4);
      ft = (m_phase == 5);
      rc = 3'(m_retries);
   endtask

   // ---------------- checking helpers ----------------
   task check_out(input string name, input logic [2:0] st, input logic [N-1:0] ro,
                  input logic ir, input logic sd, input logic ft, input logic [2:0] rc);
      n_cmp++;
      if ({state_o, rst_out, idelay_rst, seq_done, fault, retry_cnt} !== {st, ro, ir, sd, ft, rc}) begin
         n_err++;
         $display("FAIL %s @%0t: got state=%0d rst_out=%h idelay_rst=%b seq_done=%b fault=%b retry=%0d, exp state=%0d rst_out=%h idelay_rst=%b seq_done=%b fault=%b retry=%0d",
                  name, $time, state_o, rst_out, idelay_rst, seq_done, fault, retry_cnt, st, ro, ir, sd, ft, rc);
      end
   endtask

   task check_val(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d, exp %0d", name, $time, got, exp);
      end
   endtask

   // One clock: inputs applied at the falling edge, outputs checked at the next one.
   task tick(input logic l, input logic r, input logic s);
      logic [2:0] st, rc;
      logic [N-1:0] ro;
      logic ir, sd, ft;
      mmcm_locked = l; idelay_rdy = r; soft_rst_req = s;
      @(posedge sys_clk0);
      model_step(l, r, s);
      @(negedge sys_clk0);
      model_outputs(st, ro, ir, sd, ft, rc);
      check_out("model", st, ro, ir, sd, ft, rc);
   endtask

   task wait_state(input logic [2:0] s, input int budget, input logic l, input logic r, output int n);
      n = 0;
      while (state_o !== s && n < budget) begin tick(l, r, 1'b0); n++; end
      n_cmp++;
      if (state_o !== s) begin
         n_err++;
         $display("FAIL wait_state: state=%0d after %0d cycles, exp %0d", state_o, n, s);
      end
   endtask

   task wait_leave(input logic [2:0] s, input int budget, input logic l, input logic r, output int n);
      n = 0;
      while (state_o === s && n < budget) begin tick(l, r, 1'b0); n++; end
      n_cmp++;
      if (state_o === s) begin
         n_err++;
         $display("FAIL wait_leave: still state=%0d after %0d cycles", s, n);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic         l, r, s;
      int           n;
      logic [2:0]   st;
      logic [N-1:0] ro;
      logic         ir, sd, ft;
      logic [2:0]   rc;
   } vec_t;

   localparam int NV = 24;
   vec_t vt [NV];

   initial begin
      int n;
      logic r_rand;

      // Clean bring-up: 8 filter + 16 hold cycles, then a 64-cycle IDELAYCTRL reset.
      vt[0]  = '{1'b1, 1'b0, 1'b0, 23, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0};
      vt[1]  = '{1'b1, 1'b0, 1'b0,  1, 3'd1, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 63, 3'd1, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0};
      vt[3]  = '{1'b1, 1'b0, 1'b0,  1, 3'd2, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[4]  = '{1'b1, 1'b0, 1'b0,  4, 3'd2, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[5]  = '{1'b1, 1'b1, 1'b0,  1, 3'd3, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0};
      // Staged release: bits drop 8, 16, 24, 32 cycles after RELEASE entry.
      vt[6]  = '{1'b1, 1'b1, 1'b0,  7, 3'd3, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[7]  = '{1'b1, 1'b1, 1'b0,  1, 3'd3, 4'hE, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[8]  = '{1'b1, 1'b1, 1'b0,  8, 3'd3, 4'hC, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[9]  = '{1'b1, 1'b1, 1'b0,  8, 3'd3, 4'h8, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[10] = '{1'b1, 1'b1, 1'b0,  7, 3'd3, 4'h8, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[11] = '{1'b1, 1'b1, 1'b0,  1, 3'd4, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0};
      vt[12] = '{1'b1, 1'b1, 1'b0, 10, 3'd4, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0};
      // RUN disturbance: ready drops -> IDLY_RST, retries untouched.
      vt[13] = '{1'b1, 1'b0, 1'b0,  1, 3'd1, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0};
      vt[14] = '{1'b1, 1'b0, 1'b0, 64, 3'd2, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[15] = '{1'b1, 1'b1, 1'b0,  1, 3'd3, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[16] = '{1'b1, 1'b1, 1'b0, 16, 3'd3, 4'hC, 1'b0, 1'b0, 1'b0, 3'd0};
      // One-cycle lock glitch mid-RELEASE, then the whole sequence reruns.
      vt[17] = '{1'b0, 1'b1, 1'b0,  1, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0};
      vt[18] = '{1'b1, 1'b1, 1'b0, 23, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0};
      vt[19] = '{1'b1, 1'b1, 1'b0,  1, 3'd1, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0};
      vt[20] = '{1'b1, 1'b1, 1'b0, 64, 3'd2, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[21] = '{1'b1, 1'b1, 1'b0,  1, 3'd3, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0};
      vt[22] = '{1'b1, 1'b1, 1'b0,  8, 3'd3, 4'hE, 1'b0, 1'b0, 1'b0, 3'd0};
      // Software restart from RELEASE.
      vt[23] = '{1'b1, 1'b1, 1'b1,  1, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0};

      sync_rst = 1'b1; mmcm_locked = 1'b0; idelay_rdy = 1'b0; soft_rst_req = 1'b0;
      model_reset();
      repeat (2) @(negedge sys_clk0);
      check_out("reset_values", 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0);
      sync_rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         for (int j = 0; j < vt[i].n; j++) tick(vt[i].l, vt[i].r, vt[i].s);
         check_out($sformatf("vec%0d", i), vt[i].st, vt[i].ro, vt[i].ir, vt[i].sd, vt[i].ft, vt[i].rc);
      end

      // Timeout / retry into FAULT: four timed-out attempts (initial + 3 retries).
      wait_state(3'd2, 300, 1'b1, 1'b0, n);
      for (int a = 1; a <= MR; a++) begin
         wait_leave(3'd2, TO + 100, 1'b1, 1'b0, n);
         check_val("timeout_len", n, TO);
         check_out($sformatf("retry%0d", a), 3'd1, 4'hF, 1'b1, 1'b0, 1'b0, 3'(a));
         wait_state(3'd2, 200, 1'b1, 1'b0, n);
         check_val("idly_len", n, IRC);
      end
      wait_leave(3'd2, TO + 100, 1'b1, 1'b0, n);
      check_val("final_timeout_len", n, TO);
      check_out("fault_entry", 3'd5, 4'hF, 1'b1, 1'b0, 1'b1, 3'd3);
      tick(1'b0, 1'b0, 1'b0);
      check_out("fault_ignores_lockloss", 3'd5, 4'hF, 1'b1, 1'b0, 1'b1, 3'd3);
      tick(1'b1, 1'b0, 1'b1);
      check_out("fault_soft_exit", 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0);

      // Lock loss and soft request together in WAIT_RDY with two retries used.
      wait_state(3'd2, 300, 1'b1, 1'b0, n);
      for (int a = 1; a <= 2; a++) begin
         wait_leave(3'd2, TO + 100, 1'b1, 1'b0, n);
         wait_state(3'd2, 200, 1'b1, 1'b0, n);
      end
      check_out("wait_retry2", 3'd2, 4'hF, 1'b0, 1'b0, 1'b0, 3'd2);
      tick(1'b0, 1'b0, 1'b1);
      check_out("lockloss_beats_soft", 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 3'd2);

      // Ready and timeout in the same cycle: ready wins.
      wait_state(3'd2, 300, 1'b1, 1'b0, n);
      repeat (TO - 1) tick(1'b1, 1'b0, 1'b0);
      check_out("pre_timeout", 3'd2, 4'hF, 1'b0, 1'b0, 1'b0, 3'd2);
      tick(1'b1, 1'b1, 1'b0);
      check_out("rdy_beats_timeout", 3'd3, 4'hF, 1'b0, 1'b0, 1'b0, 3'd2);

      // Asynchronous reset mid-IDLY_RST, observed before the next rising edge.
      wait_state(3'd4, 100, 1'b1, 1'b1, n);
      wait_state(3'd1, 10, 1'b1, 1'b0, n);
      #2 sync_rst = 1'b1;
      #1 check_out("async_reset", 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0);
      model_reset();
      #1 sync_rst = 1'b0;
      tick(1'b1, 1'b1, 1'b0);

      // Random phase against the reference model.
      r_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) r_rand = ~r_rand;
         tick(($urandom_range(0, 199) != 0), r_rand, ($urandom_range(0, 299) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
